// File: rtl/alu_function_sequencer.sv
// Drives the {f1,f2,f3} function code to the relay ALU decode tree, holds it through a
// settle interval, strobes the destination load and optionally captures flags (ALU_FLAG_CAPTURE_EN).
module alu_function_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int LOAD_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic       dest,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic [2:0] f,
    output logic       ld_a,
    output logic       ld_d,
    output logic       ld_cond,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_s,
    output logic       busy,
    output logic       done
);

    localparam int MAX_CYC = (SETTLE_CYCLES > LOAD_CYCLES) ? SETTLE_CYCLES : LOAD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_ADD  = 3'b111;
    localparam logic [2:0] OP_INC  = 3'b011;
    localparam logic [2:0] OP_NULL = 3'b000;

    typedef enum logic [1:0] {IDLE, SETTLE, LOAD, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       op_q, op_nxt;
    logic             dest_q, dest_nxt;
    logic             cap;
    logic             drive_f, strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= OP_NULL;
            dest_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            op_q   <= op_nxt;
            dest_q <= dest_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        dest_nxt  = dest_q;
        cap       = 1'b0;
        case (state)
            IDLE: if (start) begin
                op_nxt    = opcode;
                dest_nxt  = dest;
                cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
                state_nxt = SETTLE;
            end
            SETTLE: if (cnt == '0) begin
                cnt_nxt   = CNT_W'(LOAD_CYCLES - 1);
                state_nxt = LOAD;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
            LOAD: if (cnt == '0) begin
                cap       = (op_q != OP_NULL);
                state_nxt = DONE;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up exactly with state entry.
    assign drive_f = (state_nxt == SETTLE) || (state_nxt == LOAD);
    assign strobe  = (state_nxt == LOAD) && (op_nxt != OP_NULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f    <= 3'b000;
            ld_a <= 1'b0;
            ld_d <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            f    <= drive_f ? op_nxt : 3'b000;
            ld_a <= strobe && !dest_nxt;
            ld_d <= strobe && dest_nxt;
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
        end
    end

`ifdef ALU_FLAG_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cond <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_s  <= 1'b0;
        end else begin
            ld_cond <= strobe;
            if (cap) begin
                flag_z <= (alu_result == 8'h00);
                flag_s <= alu_result[7];
                // Carry is only meaningful for the arithmetic codes; logic ops leave it alone.
                if (op_q == OP_ADD || op_q == OP_INC) flag_c <= alu_carry;
            end
        end
    end
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{alu_result, alu_carry, cap};
    assign ld_cond = 1'b0;
    assign flag_z  = 1'b0;
    assign flag_c  = 1'b0;
    assign flag_s  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_function_sequencer.sv
// Directed, table-driven bench for alu_function_sequencer: per-cycle waveform and flag checks,
// plus mid-operation reset and a minimum-timing (1/1) instance for back-to-back issue.
module tb_alu_function_sequencer;

    localparam int S = 4;
    localparam int L = 2;
`ifdef ALU_FLAG_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, dest, start1;
    logic [2:0] opcode;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic [2:0] f, f1;
    logic       ld_a, ld_d, ld_cond, flag_z, flag_c, flag_s, busy, done;
    logic       ld_a1, ld_d1, ld_cond1, flag_z1, flag_c1, flag_s1, busy1, done1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_function_sequencer #(.SETTLE_CYCLES(S), .LOAD_CYCLES(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .dest(dest),
        .alu_result(alu_result), .alu_carry(alu_carry), .f(f), .ld_a(ld_a), .ld_d(ld_d),
        .ld_cond(ld_cond), .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s),
        .busy(busy), .done(done));

    alu_function_sequencer #(.SETTLE_CYCLES(1), .LOAD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .opcode(3'b111), .dest(1'b0),
        .alu_result(alu_result), .alu_carry(alu_carry), .f(f1), .ld_a(ld_a1), .ld_d(ld_d1),
        .ld_cond(ld_cond1), .flag_z(flag_z1), .flag_c(flag_c1), .flag_s(flag_s1),
        .busy(busy1), .done(done1));

    typedef struct packed {
        logic [2:0] op;
        logic       dest;
        logic [7:0] res;
        logic       carry;
        logic       z, c, s;
        logic       inj;
    } vec_t;

    vec_t vecs [0:8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_flags(input vec_t v);
        chk("flag_z", {7'd0, flag_z}, {7'd0, CAP & v.z});
        chk("flag_c", {7'd0, flag_c}, {7'd0, CAP & v.c});
        chk("flag_s", {7'd0, flag_s}, {7'd0, CAP & v.s});
    endtask

    // Issue one op at a negedge and check every cycle through DONE and the following IDLE.
    task automatic run_op(input vec_t v);
        logic real_op;
        real_op = (v.op != 3'b000);
        alu_result = v.res;
        alu_carry  = v.carry;
        @(negedge clk);
        start = 1'b1; opcode = v.op; dest = v.dest;
        @(negedge clk);
        for (int c = 1; c <= S + L + 1; c++) begin
            start = 1'b0;
            opcode = v.op;
            if (c <= S + L) begin
                chk("f_active", {5'd0, f}, {5'd0, v.op});
                chk("ld_a", {7'd0, ld_a}, {7'd0, c > S && real_op && !v.dest});
                chk("ld_d", {7'd0, ld_d}, {7'd0, c > S && real_op && v.dest});
                chk("ld_cond", {7'd0, ld_cond}, {7'd0, c > S && real_op && CAP});
                chk("done_early", {7'd0, done}, 8'd0);
            end else begin
                chk("f_done", {5'd0, f}, 8'd0);
                chk("ld_done", {6'd0, ld_a, ld_d}, 8'd0);
                chk("done", {7'd0, done}, 8'd1);
                chk_flags(v);
            end
            chk("busy", {7'd0, busy}, 8'd1);
            // Foreign requests while busy must be ignored.
            if (v.inj && (c == 2 || c == S + 1)) begin
                start = 1'b1; opcode = v.op ^ 3'b101;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("idle_busy", {7'd0, busy}, 8'd0);
        chk("idle_done", {7'd0, done}, 8'd0);
        chk("idle_f", {5'd0, f}, 8'd0);
        chk_flags(v);
    endtask

    initial begin
        vec_t rv;
        //            op      dest  res    cy    z     c     s     inj
        vecs[0] = '{3'b111, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // ADD -> A
        vecs[1] = '{3'b110, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // XOR -> D, carry held
        vecs[2] = '{3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // NULL, flags unchanged
        vecs[3] = '{3'b011, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // INC -> D
        vecs[4] = '{3'b101, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // AND, carry held 0
        vecs[5] = '{3'b001, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // OR
        vecs[6] = '{3'b100, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // SHL
        vecs[7] = '{3'b010, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // NOT
        vecs[8] = '{3'b111, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // ADD with ignored starts

        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; opcode = 3'b000; dest = 1'b0;
        alu_result = 8'h00; alu_carry = 1'b0;
        #1;
        chk("rst_outs", {f, ld_a, ld_d, ld_cond, busy, done}, 8'd0);
        chk("rst_flags", {5'd0, flag_z, flag_c, flag_s}, 8'd0);
        chk("rst_outs1", {f1, ld_a1, ld_d1, ld_cond1, busy1, done1}, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_op(vecs[i]);

        // Reset in the second LOAD cycle discards the op.
        alu_result = 8'h80; alu_carry = 1'b1;
        @(negedge clk);
        start = 1'b1; opcode = 3'b111; dest = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (S + L - 1) @(negedge clk);
        chk("pre_rst_ld_a", {7'd0, ld_a}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {f, ld_a, ld_d, ld_cond, busy, done}, 8'd0);
        chk("mid_rst_flags", {5'd0, flag_z, flag_c, flag_s}, 8'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_no_done", {6'd0, done, busy}, 8'd0);
        end
        rst_n = 1'b1;
        rv = '{3'b110, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        run_op(rv);

        // Minimum timing instance: start held high gives a 4-clock issue period.
        @(negedge clk);
        start1 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("f1", {5'd0, f1}, ((i % 4 == 1) || (i % 4 == 2)) ? 8'd7 : 8'd0);
            chk("ld_a1", {7'd0, ld_a1}, {7'd0, i % 4 == 2});
            chk("done1", {7'd0, done1}, {7'd0, i % 4 == 3});
            chk("busy1", {7'd0, busy1}, {7'd0, i % 4 != 0});
        end
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy1_end", {7'd0, busy1}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
